// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if
//
// Purpose:
//   Groups the execute-stage multiply/divide request and the HI/LO result
//   signals into one bundle. The execute stage drives the request side, and
//   muldiv_unit owns the result side.
//
// Parameters:
//   WIDTH       operand width; HI and LO are each WIDTH bits
//
// Signals:
//   start       EX-stage instruction valid this cycle      (master -> slave)
//   alucontrol  decoded ALU operation (1000 MULT, 1001 DIV) (master -> slave)
//   hien, loen  HI/LO write enables from the decoder        (master -> slave)
//   srca, srcb  rs / rt operands                            (master -> slave)
//   busy        operation in flight, pipeline must stall    (slave -> master)
//   done        one-cycle pulse, HI/LO just updated         (slave -> master)
//   hi, lo      architectural HI / LO registers             (slave -> master)
//   div0        sticky divide-by-zero flag, present only when
//               MULDIV_DIV0_FLAG_EN is defined              (slave -> master)
//
// Configuration macro: MULDIV_DIV0_FLAG_EN
interface muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [3:0]       alucontrol;
   logic             hien;
   logic             loen;
   logic [WIDTH-1:0] srca;
   logic [WIDTH-1:0] srcb;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
`ifdef MULDIV_DIV0_FLAG_EN
   logic             div0;

   // Execute-stage view: issues requests and observes results
   modport master (
      output start, alucontrol, hien, loen, srca, srcb,
      input  busy, done, hi, lo, div0
   );

   // Unit view: consumes requests and owns HI/LO
   modport slave (
      input  start, alucontrol, hien, loen, srca, srcb,
      output busy, done, hi, lo, div0
   );
`else
   // Execute-stage view: issues requests and observes results
   modport master (
      output start, alucontrol, hien, loen, srca, srcb,
      input  busy, done, hi, lo
   );

   // Unit view: consumes requests and owns HI/LO
   modport slave (
      input  start, alucontrol, hien, loen, srca, srcb,
      output busy, done, hi, lo
   );
`endif
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit
//
// Purpose:
//   Iterative signed multiplier/divider that owns the HI and LO architectural
//   registers. It performs one shift-add (MULT) or one restoring
//   shift-subtract (DIV) step per cycle on operand magnitudes. A final cycle
//   then applies the two's-complement sign correction and writes HI/LO.
//   busy stays high from the accept edge until HI/LO are written, which is
//   WIDTH+1 cycles.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    muldiv_unit_if.slave
//            in : start, alucontrol, hien, loen, srca, srcb
//            out: busy, done, hi, lo (and div0 with MULDIV_DIV0_FLAG_EN)
//
// Configuration macro: MULDIV_DIV0_FLAG_EN
//   When this macro is defined, the design adds a div0 flag. The flag is set
//   when a divide by zero completes and is cleared on the next accepted
//   operation.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input logic          clk,
   input logic          reset,
   muldiv_unit_if.slave bus
);

   localparam logic [3:0] OP_MULT = 4'b1000;
   localparam logic [3:0] OP_DIV  = 4'b1001;
   localparam int         CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIX
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               op_div_q, op_div_d;
   logic               res_neg_q, res_neg_d;
   logic               dvd_neg_q, dvd_neg_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
`ifdef MULDIV_DIV0_FLAG_EN
   logic               div0_q, div0_d;
`endif

   logic               accept;
   logic [WIDTH-1:0]   srca_mag;
   logic [WIDTH-1:0]   srcb_mag;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] acc_step;
   logic [2*WIDTH-1:0] prod_fixed;
   logic [WIDTH-1:0]   quo_fixed;
   logic [WIDTH-1:0]   rem_fixed;
   logic [WIDTH-1:0]   dvd_restored;

   // Request qualification. The operands are reduced to magnitudes here, so
   // the datapath iterates on unsigned values only. The magnitude of the
   // most-negative value is its own bit pattern read as unsigned, which is
   // the correct magnitude.
   always_comb begin
      accept   = bus.start && !busy_q && bus.hien && bus.loen &&
                 ((bus.alucontrol == OP_MULT) || (bus.alucontrol == OP_DIV));
      srca_mag = bus.srca[WIDTH-1] ? -bus.srca : bus.srca;
      srcb_mag = bus.srcb[WIDTH-1] ? -bus.srcb : bus.srcb;
   end

   // One iteration of the shared datapath. The accumulator is used
   // differently for each operation:
   //   MULT: upper half is the running partial product; lower half starts
   //         as the multiplier and is shifted out LSB-first as product bits
   //         shift in.
   //   DIV : upper half is the partial remainder; lower half starts as the
   //         dividend and is shifted out MSB-first as quotient bits shift in.
   // The divisor magnitude is at most 2^(WIDTH-1), so the remainder always
   // fits in WIDTH bits. Only the shifted trial value needs one extra bit.
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
      div_shift = acc_q[2*WIDTH-1:WIDTH-1];
      div_diff  = div_shift - {1'b0, b_q};
      if (op_div_q) begin
         if (!div_diff[WIDTH]) begin
            acc_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
         end else begin
            acc_step = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_step = {mul_sum, acc_q[WIDTH-1:1]};
      end
   end

   // Sign correction for the final write. The quotient takes the XOR of the
   // operand signs, and the remainder takes the sign of the dividend. The
   // untouched dividend is rebuilt from its magnitude and sign for the
   // divide-by-zero result, which avoids keeping a second copy of srca.
   always_comb begin
      prod_fixed   = res_neg_q ? -acc_q : acc_q;
      quo_fixed    = res_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem_fixed    = dvd_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      dvd_restored = dvd_neg_q ? -a_q : a_q;
   end

   // Control FSM and next-state values. HI/LO are written only in FIX, so
   // they hold steady for the whole time busy is high. done is high for
   // exactly the one cycle after FIX. An accept is therefore legal while
   // done is high, because the state is already back in IDLE.
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      op_div_d  = op_div_q;
      res_neg_d = res_neg_q;
      dvd_neg_d = dvd_neg_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
`ifdef MULDIV_DIV0_FLAG_EN
      div0_d    = div0_q;
`endif
      case (state_q)
         IDLE: begin
            if (accept) begin
               a_d       = srca_mag;
               b_d       = srcb_mag;
               op_div_d  = (bus.alucontrol == OP_DIV);
               res_neg_d = bus.srca[WIDTH-1] ^ bus.srcb[WIDTH-1];
               dvd_neg_d = bus.srca[WIDTH-1];
               acc_d     = (bus.alucontrol == OP_DIV) ? {{WIDTH{1'b0}}, srca_mag}
                                                      : {{WIDTH{1'b0}}, srcb_mag};
               cnt_d     = CNT_W'(WIDTH - 1);
               busy_d    = 1'b1;
               state_d   = RUN;
`ifdef MULDIV_DIV0_FLAG_EN
               div0_d    = 1'b0;
`endif
            end
         end
         RUN: begin
            acc_d = acc_step;
            if (cnt_q == '0) begin
               state_d = FIX;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         FIX: begin
            if (!op_div_q) begin
               hi_d = prod_fixed[2*WIDTH-1:WIDTH];
               lo_d = prod_fixed[WIDTH-1:0];
            end else if (b_q == '0) begin
               hi_d = dvd_restored;
               lo_d = '1;
            end else begin
               hi_d = rem_fixed;
               lo_d = quo_fixed;
            end
`ifdef MULDIV_DIV0_FLAG_EN
            div0_d  = op_div_q && (b_q == '0);
`endif
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State register. Reset aborts any operation in flight immediately.
   // Because done is cleared here as well, an aborted operation never
   // produces a done pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         op_div_q  <= 1'b0;
         res_neg_q <= 1'b0;
         dvd_neg_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef MULDIV_DIV0_FLAG_EN
         div0_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         op_div_q  <= op_div_d;
         res_neg_q <= res_neg_d;
         dvd_neg_q <= dvd_neg_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
`ifdef MULDIV_DIV0_FLAG_EN
         div0_q    <= div0_d;
`endif
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
`ifdef MULDIV_DIV0_FLAG_EN
   assign bus.div0 = div0_q;
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
//
// Purpose:
//   Self-checking bench for muldiv_unit. Directed cases cover the documented
//   corner behaviour, and randomized operands cover general arithmetic.
//   Expected HI/LO values come from plain 64-bit signed arithmetic.
//
// Configuration macro: MULDIV_DIV0_FLAG_EN (div0 is also checked when defined)
module tb_muldiv_unit;

   localparam int         WIDTH   = 32;
   localparam int         LATENCY = WIDTH + 1;
   localparam logic [3:0] OP_MULT = 4'b1000;
   localparam logic [3:0] OP_DIV  = 4'b1001;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_pass   = 0;

   muldiv_unit_if #(.WIDTH(WIDTH)) bus ();

   muldiv_unit #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running clock, 10 time units per period
   always #5 clk = ~clk;

   // Counts one comparison and reports it if the values differ
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      n_checks++;
      if (observed === expected) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
   endtask

   // Reference results from 64-bit signed arithmetic. The division operator
   // truncates toward zero, and the remainder takes the dividend's sign.
   // Most-negative / -1 does not overflow at 64 bits.
   function automatic void refModel(input bit is_div, input logic [31:0] a,
                                    input logic [31:0] b,
                                    output logic [31:0] exp_hi,
                                    output logic [31:0] exp_lo);
      longint sa, sb, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (!is_div) begin
         r      = sa * sb;
         exp_hi = r[63:32];
         exp_lo = r[31:0];
      end else if (b == 32'h0) begin
         exp_hi = a;
         exp_lo = 32'hFFFF_FFFF;
      end else begin
         r      = sa / sb;
         exp_lo = r[31:0];
         r      = sa % sb;
         exp_hi = r[31:0];
      end
   endfunction

   // Drives one request onto the bus for the current cycle
   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic hi_en,
                                input logic lo_en);
      bus.start      = 1'b1;
      bus.alucontrol = op;
      bus.hien       = hi_en;
      bus.loen       = lo_en;
      bus.srca       = a;
      bus.srcb       = b;
   endtask

   // Issues one operation and follows it to completion. The task checks the
   // latency, that HI/LO do not move while busy, the single done pulse, and
   // the results. With chain set, it returns in the done cycle so that the
   // caller can issue back-to-back work.
   task automatic runOp(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                        input bit chain, input string tag);
      logic [31:0] exp_hi, exp_lo, held_hi, held_lo;
      int          cycles;
      bit          moved, early_done;
      refModel(is_div, a, b, exp_hi, exp_lo);
      held_hi = bus.hi;
      held_lo = bus.lo;
      applyStimulus(is_div ? OP_DIV : OP_MULT, a, b, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      bus.start  = 1'b0;
      cycles     = 0;
      moved      = 1'b0;
      early_done = 1'b0;
      while (bus.busy === 1'b1 && cycles < 200) begin
         if (bus.hi !== held_hi || bus.lo !== held_lo) moved = 1'b1;
         if (bus.done !== 1'b0) early_done = 1'b1;
         @(posedge clk);
         #1;
         cycles++;
      end
      checkOutput({tag, "_latency"}, 64'(cycles), 64'(LATENCY));
      checkOutput({tag, "_hold"}, {63'h0, moved}, 64'h0);
      checkOutput({tag, "_early_done"}, {63'h0, early_done}, 64'h0);
      checkOutput({tag, "_done"}, {63'h0, bus.done}, 64'h1);
      checkOutput({tag, "_hi"}, {32'h0, bus.hi}, {32'h0, exp_hi});
      checkOutput({tag, "_lo"}, {32'h0, bus.lo}, {32'h0, exp_lo});
`ifdef MULDIV_DIV0_FLAG_EN
      checkOutput({tag, "_div0"}, {63'h0, bus.div0}, {63'h0, (is_div && b == 32'h0)});
`endif
      if (!chain) begin
         @(posedge clk);
         #1;
         checkOutput({tag, "_done_drop"}, {63'h0, bus.done}, 64'h0);
      end
   endtask

   // Main sequence: reset, directed cases, ignored requests, stall and
   // reset-abort scenarios, and finally randomized operands
   initial begin
      logic [31:0] held_hi, held_lo, ra, rb;
      int          cycles;
      bit          saw_done;
      bit          rdiv;

      reset          = 1'b1;
      bus.start      = 1'b0;
      bus.alucontrol = 4'h0;
      bus.hien       = 1'b0;
      bus.loen       = 1'b0;
      bus.srca       = '0;
      bus.srcb       = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_busy", {63'h0, bus.busy}, 64'h0);
      checkOutput("reset_done", {63'h0, bus.done}, 64'h0);
      checkOutput("reset_hi", {32'h0, bus.hi}, 64'h0);
      checkOutput("reset_lo", {32'h0, bus.lo}, 64'h0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Directed arithmetic cases
      runOp(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0, "mult_7_m3");
      checkOutput("mult_7_m3_hi_const", {32'h0, bus.hi}, 64'hFFFF_FFFF);
      checkOutput("mult_7_m3_lo_const", {32'h0, bus.lo}, 64'hFFFF_FFEB);
      runOp(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, "mult_minmin");
      checkOutput("mult_minmin_hi_const", {32'h0, bus.hi}, 64'h4000_0000);
      runOp(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_m7_2");
      checkOutput("div_m7_2_lo_const", {32'h0, bus.lo}, 64'hFFFF_FFFD);
      runOp(1'b1, 32'd5, 32'd0, 1'b0, "div_by_zero");
      checkOutput("div_by_zero_hi_const", {32'h0, bus.hi}, 64'h5);
      runOp(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_min_m1");
      checkOutput("div_min_m1_lo_const", {32'h0, bus.lo}, 64'h8000_0000);

      // Requests that must be ignored: wrong opcode or a missing enable
      held_hi = bus.hi;
      held_lo = bus.lo;
      for (int i = 0; i < 4; i++) begin
         case (i)
            0:       applyStimulus(4'b0000, 32'd3, 32'd3, 1'b1, 1'b1);
            1:       applyStimulus(OP_MULT, 32'd3, 32'd3, 1'b0, 1'b1);
            2:       applyStimulus(OP_DIV,  32'd3, 32'd3, 1'b1, 1'b0);
            default: applyStimulus(4'b1010, 32'd3, 32'd3, 1'b1, 1'b1);
         endcase
         @(posedge clk);
         #1;
         bus.start = 1'b0;
         checkOutput($sformatf("ignored%0d_busy", i), {63'h0, bus.busy}, 64'h0);
         @(posedge clk);
         #1;
         checkOutput($sformatf("ignored%0d_hilo", i), {bus.hi, bus.lo}, {held_hi, held_lo});
      end

      // A start while busy is dropped. A start in the done cycle is taken.
      applyStimulus(OP_MULT, 32'd3, 32'd4, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      cycles    = 0;
      while (bus.busy === 1'b1 && cycles < 200) begin
         if (cycles == 9) applyStimulus(OP_DIV, 32'd100, 32'd7, 1'b1, 1'b1);
         else bus.start = 1'b0;
         @(posedge clk);
         #1;
         cycles++;
      end
      bus.start = 1'b0;
      checkOutput("stall_latency", 64'(cycles), 64'(LATENCY));
      checkOutput("stall_done", {63'h0, bus.done}, 64'h1);
      checkOutput("stall_hi", {32'h0, bus.hi}, 64'h0);
      checkOutput("stall_lo", {32'h0, bus.lo}, 64'd12);
      runOp(1'b1, 32'd100, 32'd7, 1'b0, "div_in_done");
      checkOutput("div_in_done_lo_const", {32'h0, bus.lo}, 64'd14);
      checkOutput("div_in_done_hi_const", {32'h0, bus.hi}, 64'd2);

      // Reset partway through a multiply aborts it without a done pulse
      runOp(1'b1, 32'd68, 32'd7, 1'b0, "prime_5_9");
      applyStimulus(OP_MULT, 32'd6, 32'd6, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (14) begin
         @(posedge clk);
         #1;
      end
      #2;
      reset = 1'b1;
      #1;
      checkOutput("abort_busy", {63'h0, bus.busy}, 64'h0);
      checkOutput("abort_done", {63'h0, bus.done}, 64'h0);
      checkOutput("abort_hilo", {bus.hi, bus.lo}, 64'h0);
      @(posedge clk);
      #1;
      reset    = 1'b0;
      saw_done = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) saw_done = 1'b1;
      end
      checkOutput("abort_quiet", {63'h0, saw_done}, 64'h0);
      runOp(1'b0, 32'd6, 32'd6, 1'b0, "reissue_6x6");
      checkOutput("reissue_6x6_lo_const", {32'h0, bus.lo}, 64'd36);

      // Randomized operands with occasional corner values
      for (int n = 0; n < 30; n++) begin
         rdiv = 1'($urandom_range(0, 1));
         ra   = $urandom;
         rb   = $urandom;
         case ($urandom_range(0, 7))
            0:       rb = 32'h0;
            1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2:       rb = 32'($urandom_range(1, 15));
            3:       ra = 32'($urandom_range(0, 15));
            4:       rb = -32'($urandom_range(1, 15));
            default: ;
         endcase
         runOp(rdiv, ra, rb, 1'($urandom_range(0, 1)), $sformatf("rand%0d", n));
      end

      @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Execute-stage consumer of the ALU decoder's multiply/divide controls (alucontrol 4'b1000 MULT, 4'b1001 DIV; hien/loen both high).
- Iterative signed 32-bit multiplier/divider that owns the HI and LO architectural registers.
- Asserts busy so the hazard unit can stall.
- hi/lo outputs feed the mfhi/mflo result mux.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; one iteration per cycle.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  EX-stage instruction valid this cycle
- alucontrol  input  4  decoded ALU operation
- hien  input  1  HI write enable from decoder
- loen  input  1  LO write enable from decoder
- srca  input  WIDTH  rs operand (multiplicand / dividend)
- srcb  input  WIDTH  rt operand (multiplier / divisor)
- busy  output  1  operation in flight; pipeline must stall
- done  output  1  one-cycle pulse: HI/LO just updated
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- div0  output  1  present only with MULDIV_DIV0_FLAG_EN

Behaviour:
- One clock, clk. Reset is asynchronous and active-high. reset forces:
  - state IDLE
  - hi=0, lo=0, busy=0, done=0 (and div0=0 when the optional feature is compiled in)
  - internal operand, accumulator and counter registers to 0
- Accept condition: start & !busy & hien & loen & alucontrol in {1000,1001}.
  - Any other combination is ignored; no state change.
- start while busy: ignored. Stalling the pipeline is upstream's job; no queuing.
- States:
  - IDLE: on accept, latch |srca|, |srcb|, result sign, dividend sign, op; load counter=WIDTH-1; go to RUN.
  - RUN: one shift-add (MULT) or one restoring shift-subtract (DIV) step per cycle. Go to FIX when counter==0; otherwise decrement the counter.
  - FIX: apply two's-complement sign correction, write hi/lo, go to IDLE.
- busy=1 in RUN and FIX; it is a registered output.
- Latency:
  - Accept on edge E.
  - busy high for WIDTH+1 cycles.
  - hi/lo updated and busy falls on edge E+WIDTH+1 (33 cycles for WIDTH=32).
  - done=1 for exactly the following cycle.
- A new operation may be accepted in the cycle done=1.
- MULT: full signed 2*WIDTH product; hi=upper half, lo=lower half.
- DIV (srcb!=0):
  - lo = quotient truncated toward zero.
  - hi = remainder carrying the dividend's sign.
  - Most-negative / -1: lo=0x80000000, hi=0; no trap.
- DIV by zero: lo=all ones, hi=srca (unmodified dividend); same latency.
- hi/lo hold their value between operations and never change while busy.
- Reset mid-operation: aborts immediately; hi/lo go to 0; no done pulse.

Optional Feature:
- Macro: MULDIV_DIV0_FLAG_EN.
- Defined:
  - Adds output div0.
  - div0 is set on the FIX edge of a DIV whose latched divisor was 0.
  - div0 is cleared on the next accepted operation or on reset.
- Undefined: port absent. Divide-by-zero results are as specified above, with no indication.

Test Plan:
- MULT srca=7, srcb=0xFFFFFFFD (-3) -> busy for 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB, done pulses once.
- MULT 0x80000000 * 0x80000000 -> hi=0x40000000, lo=0x00000000.
- DIV srca=0xFFFFFFF9 (-7), srcb=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV srca=5, srcb=0 -> lo=0xFFFFFFFF, hi=0x00000005; div0=1 if MULDIV_DIV0_FLAG_EN defined.
- Start MULT 3*4; assert start with DIV 100/7 at cycle 10 while busy -> second op ignored, hi=0, lo=12. Then issue DIV in the done cycle -> accepted, lo=14, hi=2.
- Start MULT 6*6 with prior hi/lo=5/9; assert reset at cycle 15 -> hi=lo=0, busy=0, no done. Re-issue after reset -> lo=36.
